// File: rtl/arcade_input_pkg.sv
// Shared constants for the arcade input conditioner: scan codes, button bit
// positions and the coin FSM state type.
package arcade_input_pkg;

  // Bit positions inside the 8-bit per-player button vector
  localparam int unsigned BtnRight = 0;
  localparam int unsigned BtnLeft  = 1;
  localparam int unsigned BtnDown  = 2;
  localparam int unsigned BtnUp    = 3;
  localparam int unsigned BtnFireA = 4;
  localparam int unsigned BtnFireB = 5;
  localparam int unsigned BtnFireC = 6;
  localparam int unsigned BtnFireD = 7;

  // Player 1 scan codes
  localparam logic [7:0] KeyP1Up    = 8'h75;
  localparam logic [7:0] KeyP1Down  = 8'h72;
  localparam logic [7:0] KeyP1Left  = 8'h6B;
  localparam logic [7:0] KeyP1Right = 8'h74;
  localparam logic [7:0] KeyP1FireA = 8'h14;
  localparam logic [7:0] KeyP1FireB = 8'h11;
  localparam logic [7:0] KeyP1FireC = 8'h29;
  localparam logic [7:0] KeyP1FireD = 8'h12;

  // Player 2 scan codes
  localparam logic [7:0] KeyP2Up    = 8'h2D;
  localparam logic [7:0] KeyP2Down  = 8'h2B;
  localparam logic [7:0] KeyP2Left  = 8'h23;
  localparam logic [7:0] KeyP2Right = 8'h34;
  localparam logic [7:0] KeyP2FireA = 8'h1C;
  localparam logic [7:0] KeyP2FireB = 8'h1B;
  localparam logic [7:0] KeyP2FireC = 8'h21;
  localparam logic [7:0] KeyP2FireD = 8'h1D;

  // System scan codes
  localparam logic [7:0] KeyStart1A = 8'h05;
  localparam logic [7:0] KeyStart1B = 8'h16;
  localparam logic [7:0] KeyStart2A = 8'h06;
  localparam logic [7:0] KeyStart2B = 8'h1E;
  localparam logic [7:0] KeyCoinA1  = 8'h76;
  localparam logic [7:0] KeyCoinA2  = 8'h2E;
  localparam logic [7:0] KeyCoinB   = 8'h36;

  typedef enum logic [1:0] {IDLE, PULSE, LOCK} coin_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/coin_pulse_gen.sv
// Coin pulse generator: registered edge detect on the raw coin request, then a
// fixed-width pulse followed by a lockout. Edges outside IDLE are dropped.
module coin_pulse_gen
  import arcade_input_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES = 1,
  parameter int unsigned LOCK_CYCLES  = 1
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic coin_raw,
  output logic coin_pulse
);

  localparam int unsigned CntMax = max_u(PULSE_CYCLES, LOCK_CYCLES);
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  if (PULSE_CYCLES == 0) begin : g_bad_pulse
    $error("coin_pulse_gen: PULSE_CYCLES must be nonzero");
  end
  if (LOCK_CYCLES == 0) begin : g_bad_lock
    $error("coin_pulse_gen: LOCK_CYCLES must be nonzero");
  end

  logic            raw_q;
  logic            raw_prev_q;
  logic            rise;
  coin_state_t     state_q;
  logic [CntW-1:0] cnt_q;

  assign rise = raw_q & ~raw_prev_q;

  // Register the raw request and its previous value for edge detection
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      raw_q      <= 1'b0;
      raw_prev_q <= 1'b0;
    end else begin
      raw_q      <= coin_raw;
      raw_prev_q <= raw_q;
    end
  end

  // Coin FSM; counter holds remaining cycles in the current phase (N..1)
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      coin_pulse <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            state_q    <= PULSE;
            cnt_q      <= CntW'(PULSE_CYCLES);
            coin_pulse <= 1'b1;
          end
        end
        PULSE: begin
          if (cnt_q == CntW'(1)) begin
            state_q    <= LOCK;
            cnt_q      <= CntW'(LOCK_CYCLES);
            coin_pulse <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        LOCK: begin
          if (cnt_q == CntW'(1)) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: begin
          state_q    <= IDLE;
          cnt_q      <= '0;
          coin_pulse <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/arcade_input_conditioner.sv
// Arcade input conditioner: decodes PS/2 key events into latched buttons,
// merges them with HPS joysticks into registered per-player vectors and drives
// a conditioned coin pulse. Optional autofire on fireA is enabled by the
// AUTOFIRE_EN macro.
module arcade_input_conditioner
  import arcade_input_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 10_000_000,
  parameter int unsigned COIN_PULSE_MS = 100,
  parameter int unsigned COIN_LOCK_MS  = 100,
  parameter int unsigned AUTOFIRE_HZ   = 10
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joy1,
  input  logic [15:0] joy2,
  output logic [7:0]  p1_btn,
  output logic [7:0]  p2_btn,
  output logic        start1,
  output logic        start2,
  output logic        coin1
);

  localparam longint unsigned PulseCyc64 = 64'(COIN_PULSE_MS) * 64'(CLK_HZ) / 64'd1000;
  localparam longint unsigned LockCyc64  = 64'(COIN_LOCK_MS) * 64'(CLK_HZ) / 64'd1000;
  localparam int unsigned     PulseCycles = 32'(PulseCyc64);
  localparam int unsigned     LockCycles  = 32'(LockCyc64);

  if (AUTOFIRE_HZ == 0) begin : g_bad_af
    $error("arcade_input_conditioner: AUTOFIRE_HZ must be nonzero");
  end

  logic       tog_q;
  logic       primed_q;
  logic       key_event;
  logic       pressed;
  logic [7:0] key_p1;
  logic [7:0] key_p2;
  logic       key_start1;
  logic       key_start2;
  logic       key_coin_a;
  logic       key_coin_b;
  logic [7:0] p1_next;
  logic [7:0] p2_next;
  logic       coin_raw;
  logic       unused_bits;

  // Extended-key flag and high joystick bits carry nothing this block needs
  assign unused_bits = ^{ps2_key[8], joy1[15:11], joy2[15:11]};

  assign key_event = primed_q & (ps2_key[10] ^ tog_q);
  assign pressed   = ps2_key[9];

  // Key event detection and per-key latches; first cycle only primes the toggle
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      tog_q      <= 1'b0;
      primed_q   <= 1'b0;
      key_p1     <= '0;
      key_p2     <= '0;
      key_start1 <= 1'b0;
      key_start2 <= 1'b0;
      key_coin_a <= 1'b0;
      key_coin_b <= 1'b0;
    end else begin
      tog_q    <= ps2_key[10];
      primed_q <= 1'b1;
      if (key_event) begin
        case (ps2_key[7:0])
          KeyP1Right:             key_p1[BtnRight] <= pressed;
          KeyP1Left:              key_p1[BtnLeft]  <= pressed;
          KeyP1Down:              key_p1[BtnDown]  <= pressed;
          KeyP1Up:                key_p1[BtnUp]    <= pressed;
          KeyP1FireA:             key_p1[BtnFireA] <= pressed;
          KeyP1FireB:             key_p1[BtnFireB] <= pressed;
          KeyP1FireC:             key_p1[BtnFireC] <= pressed;
          KeyP1FireD:             key_p1[BtnFireD] <= pressed;
          KeyP2Right:             key_p2[BtnRight] <= pressed;
          KeyP2Left:              key_p2[BtnLeft]  <= pressed;
          KeyP2Down:              key_p2[BtnDown]  <= pressed;
          KeyP2Up:                key_p2[BtnUp]    <= pressed;
          KeyP2FireA:             key_p2[BtnFireA] <= pressed;
          KeyP2FireB:             key_p2[BtnFireB] <= pressed;
          KeyP2FireC:             key_p2[BtnFireC] <= pressed;
          KeyP2FireD:             key_p2[BtnFireD] <= pressed;
          KeyStart1A, KeyStart1B: key_start1       <= pressed;
          KeyStart2A, KeyStart2B: key_start2       <= pressed;
          KeyCoinA1, KeyCoinA2:   key_coin_a       <= pressed;
          KeyCoinB:               key_coin_b       <= pressed;
          default: ;
        endcase
      end
    end
  end

`ifdef AUTOFIRE_EN
  localparam int unsigned AfHalf = CLK_HZ / (2 * AUTOFIRE_HZ);
  localparam int unsigned AfW    = (AfHalf > 1) ? $clog2(AfHalf) : 1;

  if (AfHalf == 0) begin : g_bad_af_half
    $error("arcade_input_conditioner: CLK_HZ too low for AUTOFIRE_HZ");
  end

  logic           p1_fire_d;
  logic           p2_fire_d;
  logic           af_held;
  logic           phase_q;
  logic [AfW-1:0] af_cnt_q;

  assign p1_fire_d = key_p1[BtnFireD] | joy1[BtnFireD];
  assign p2_fire_d = key_p2[BtnFireD] | joy2[BtnFireD];
  assign af_held   = p1_fire_d | p2_fire_d;

  // Shared autofire phase: high on the first held cycle, toggles every AfHalf cycles
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      phase_q  <= 1'b1;
      af_cnt_q <= '0;
    end else if (!af_held) begin
      phase_q  <= 1'b1;
      af_cnt_q <= '0;
    end else if (af_cnt_q == AfW'(AfHalf - 1)) begin
      phase_q  <= ~phase_q;
      af_cnt_q <= '0;
    end else begin
      af_cnt_q <= af_cnt_q + AfW'(1);
    end
  end

  // Merge keys and joysticks, then OR the autofire phase into fireA
  always_comb begin
    p1_next = key_p1 | joy1[7:0];
    p2_next = key_p2 | joy2[7:0];
    p1_next[BtnFireA] = p1_next[BtnFireA] | (p1_fire_d & phase_q);
    p2_next[BtnFireA] = p2_next[BtnFireA] | (p2_fire_d & phase_q);
  end
`else
  // Merge keys and joysticks
  always_comb begin
    p1_next = key_p1 | joy1[7:0];
    p2_next = key_p2 | joy2[7:0];
  end
`endif

  // Registered button and start outputs
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      p1_btn <= '0;
      p2_btn <= '0;
      start1 <= 1'b0;
      start2 <= 1'b0;
    end else begin
      p1_btn <= p1_next;
      p2_btn <= p2_next;
      start1 <= key_start1 | joy1[8] | joy2[8];
      start2 <= key_start2 | joy1[9] | joy2[9];
    end
  end

  assign coin_raw = key_coin_a | key_coin_b | joy1[10] | joy2[10];

  coin_pulse_gen #(
    .PULSE_CYCLES(PulseCycles),
    .LOCK_CYCLES (LockCycles)
  ) u_coin (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .coin_raw  (coin_raw),
    .coin_pulse(coin1)
  );

endmodule

// File: tb/tb_arcade_input_conditioner.sv
// Directed bench for arcade_input_conditioner. Pulse = 20 cycles, lock = 30
// cycles, autofire half-period = 5 cycles. Define AUTOFIRE_EN to match an RTL
// build with autofire.
module tb_arcade_input_conditioner;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [15:0] joy1;
  logic [15:0] joy2;
  logic [7:0]  p1_btn;
  logic [7:0]  p2_btn;
  logic        start1;
  logic        start2;
  logic        coin1;

  int n_checks = 0;
  int n_fail   = 0;

  arcade_input_conditioner #(
    .CLK_HZ       (10000),
    .COIN_PULSE_MS(2),
    .COIN_LOCK_MS (3),
    .AUTOFIRE_HZ  (1000)
  ) dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .ps2_key(ps2_key),
    .joy1   (joy1),
    .joy2   (joy2),
    .p1_btn (p1_btn),
    .p2_btn (p2_btn),
    .start1 (start1),
    .start2 (start2),
    .coin1  (coin1)
  );

  always #5 clk_sys = ~clk_sys;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  // Send a key event: flip the toggle bit, set pressed flag and code
  task automatic send_key(input logic prs, input logic [8:0] code);
    ps2_key = {~ps2_key[10], prs, code};
  endtask

  // Run n cycles and count coin1 high cycles and rising transitions
  task automatic run_count(input int n, output int highs, output int rises);
    logic prev;
    prev  = coin1;
    highs = 0;
    rises = 0;
    for (int i = 0; i < n; i++) begin
      step(1);
      if (coin1) highs++;
      if (coin1 && !prev) rises++;
      prev = coin1;
    end
  endtask

  task automatic test_reset;
    reset   = 1'b1;
    ps2_key = 11'h400;
    joy1    = '0;
    joy2    = '0;
    step(3);
    n_checks++;
    if ({p1_btn, p2_btn, start1, start2, coin1} !== 19'd0) begin
      $display("FAIL reset_hold: outputs=%h required 0", {p1_btn, p2_btn, start1, start2, coin1});
      n_fail++;
    end
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      n_checks++;
      if ({p1_btn, p2_btn, start1, start2, coin1} !== 19'd0) begin
        $display("FAIL reset_quiet cyc %0d: outputs=%h required 0", i,
                 {p1_btn, p2_btn, start1, start2, coin1});
        n_fail++;
      end
    end
  endtask

  task automatic test_keys;
    send_key(1'b1, 9'h014);
    step(1);
    n_checks++;
    if (p1_btn !== 8'h00) begin
      $display("FAIL key_latency_1cyc: p1_btn=%h required 00", p1_btn);
      n_fail++;
    end
    step(1);
    n_checks++;
    if (p1_btn !== 8'h10) begin
      $display("FAIL key_fireA_press: p1_btn=%h required 10", p1_btn);
      n_fail++;
    end
    send_key(1'b0, 9'h014);
    step(2);
    n_checks++;
    if (p1_btn !== 8'h00) begin
      $display("FAIL key_fireA_release: p1_btn=%h required 00", p1_btn);
      n_fail++;
    end
    // extended flag set must still match up
    send_key(1'b1, 9'h175);
    step(2);
    n_checks++;
    if (p1_btn !== 8'h08) begin
      $display("FAIL key_up_extended: p1_btn=%h required 08", p1_btn);
      n_fail++;
    end
    send_key(1'b1, 9'h01B);
    step(2);
    n_checks++;
    if (p2_btn !== 8'h20) begin
      $display("FAIL key_p2_fireB: p2_btn=%h required 20", p2_btn);
      n_fail++;
    end
    send_key(1'b1, 9'h016);
    step(2);
    n_checks++;
    if (start1 !== 1'b1) begin
      $display("FAIL key_start1: start1=%b required 1", start1);
      n_fail++;
    end
    // unmatched code, even a release, leaves everything alone
    send_key(1'b0, 9'h099);
    step(2);
    n_checks++;
    if ({p1_btn, p2_btn, start1, start2} !== {8'h08, 8'h20, 1'b1, 1'b0}) begin
      $display("FAIL key_unmatched: outputs=%h required %h", {p1_btn, p2_btn, start1, start2},
               {8'h08, 8'h20, 1'b1, 1'b0});
      n_fail++;
    end
    send_key(1'b0, 9'h075);
    step(1);
    send_key(1'b0, 9'h01B);
    step(1);
    send_key(1'b0, 9'h005);
    step(2);
    n_checks++;
    if ({p1_btn, p2_btn, start1, start2} !== 18'd0) begin
      $display("FAIL key_all_released: outputs=%h required 0", {p1_btn, p2_btn, start1, start2});
      n_fail++;
    end
  endtask

  task automatic test_joy;
    joy1 = 16'h0005;
    step(1);
    n_checks++;
    if (p1_btn !== 8'h05) begin
      $display("FAIL joy1_latency: p1_btn=%h required 05", p1_btn);
      n_fail++;
    end
    joy2 = 16'h0242;
    step(1);
    n_checks++;
    if ({p2_btn, start1, start2} !== {8'h42, 1'b0, 1'b1}) begin
      $display("FAIL joy2_start2: got=%h required %h", {p2_btn, start1, start2},
               {8'h42, 1'b0, 1'b1});
      n_fail++;
    end
    joy1 = 16'h0100;
    joy2 = 16'h0000;
    send_key(1'b1, 9'h06B);
    step(2);
    n_checks++;
    if ({p1_btn, start1, start2} !== {8'h02, 1'b1, 1'b0}) begin
      $display("FAIL joy_key_merge: got=%h required %h", {p1_btn, start1, start2},
               {8'h02, 1'b1, 1'b0});
      n_fail++;
    end
    joy1 = '0;
    send_key(1'b0, 9'h06B);
    step(2);
    n_checks++;
    if ({p1_btn, start1} !== 9'd0) begin
      $display("FAIL joy_clear: got=%h required 0", {p1_btn, start1});
      n_fail++;
    end
  endtask

  task automatic test_coin_hold;
    int highs;
    int rises;
    joy2[10] = 1'b1;
    step(1);
    n_checks++;
    if (coin1 !== 1'b0) begin
      $display("FAIL coin_latency_1cyc: coin1=%b required 0", coin1);
      n_fail++;
    end
    step(1);
    n_checks++;
    if (coin1 !== 1'b1) begin
      $display("FAIL coin_latency_2cyc: coin1=%b required 1", coin1);
      n_fail++;
    end
    run_count(198, highs, rises);
    n_checks++;
    if (highs + 1 !== 20 || rises !== 0) begin
      $display("FAIL coin_hold: high cycles=%0d extra rises=%0d required 20 and 0", highs + 1,
               rises);
      n_fail++;
    end
    joy2[10] = 1'b0;
    step(5);
  endtask

  task automatic test_coin_lockout;
    int h1;
    int r1;
    int h2;
    int r2;
    joy1[10] = 1'b1;
    run_count(5, h1, r1);
    joy1[10] = 1'b0;
    run_count(26, h2, r2);
    n_checks++;
    if (h1 + h2 !== 20 || r1 + r2 !== 1) begin
      $display("FAIL coin_first_pulse: highs=%0d rises=%0d required 20 and 1", h1 + h2,
               r1 + r2);
      n_fail++;
    end
    // new edge ~10 cycles into LOCK, held past the end of LOCK
    joy1[10] = 1'b1;
    run_count(30, h1, r1);
    n_checks++;
    if (h1 !== 0) begin
      $display("FAIL coin_edge_in_lock: high cycles=%0d required 0", h1);
      n_fail++;
    end
    joy1[10] = 1'b0;
    run_count(30, h1, r1);
    n_checks++;
    if (h1 !== 0) begin
      $display("FAIL coin_idle_quiet: high cycles=%0d required 0", h1);
      n_fail++;
    end
    joy1[10] = 1'b1;
    run_count(40, h1, r1);
    n_checks++;
    if (h1 !== 20 || r1 !== 1) begin
      $display("FAIL coin_after_lock: highs=%0d rises=%0d required 20 and 1", h1, r1);
      n_fail++;
    end
    joy1[10] = 1'b0;
    step(40);
  endtask

  task automatic test_coin_reset;
    int h1;
    int r1;
    joy2[10] = 1'b1;
    step(6);
    n_checks++;
    if (coin1 !== 1'b1) begin
      $display("FAIL coin_mid_pulse: coin1=%b required 1", coin1);
      n_fail++;
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (coin1 !== 1'b0) begin
      $display("FAIL coin_async_reset: coin1=%b required 0", coin1);
      n_fail++;
    end
    joy2[10] = 1'b0;
    step(3);
    reset = 1'b0;
    step(3);
    joy2[10] = 1'b1;
    run_count(40, h1, r1);
    n_checks++;
    if (h1 !== 20 || r1 !== 1) begin
      $display("FAIL coin_after_reset: highs=%0d rises=%0d required 20 and 1", h1, r1);
      n_fail++;
    end
    joy2[10] = 1'b0;
    step(40);
  endtask

  task automatic test_autofire;
    logic exp_a;
    joy1[7] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
`ifdef AUTOFIRE_EN
      exp_a = ((i / 5) % 2) == 0;
`else
      exp_a = 1'b0;
`endif
      n_checks++;
      if (p1_btn[4] !== exp_a || p1_btn[7] !== 1'b1) begin
        $display("FAIL autofire cyc %0d: fireA=%b fireD=%b required %b and 1", i, p1_btn[4],
                 p1_btn[7], exp_a);
        n_fail++;
      end
    end
    joy1[7] = 1'b0;
    step(2);
    n_checks++;
    if (p1_btn !== 8'h00) begin
      $display("FAIL autofire_release: p1_btn=%h required 00", p1_btn);
      n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_keys();
    test_joy();
    test_coin_hold();
    test_coin_lockout();
    test_coin_reset();
    test_autofire();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
